mod_n_counter: RTL and testbench

Parametrised, cascadable modulo-N up/down counter. It is the next generation of the fixed mod-60 counter in the alarm-clock datapath. It adds synchronous load with range checking, a terminal-count output for chaining stages, and registered BCD digit outputs that drive the seven-segment display logic directly. One instance serves as the seconds, minutes or hours stage (MODULUS = 60, 60, 24 or 12), and instances chain through `tc`/`en`.

---
 rtl/mod_n_counter.sv | 116 +++++++++++
 tb/tb_mod_n_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_counter.sv
// Cascadable modulo-N up/down counter with range-checked synchronous load,
// terminal-count output for chaining, and registered BCD digits kept in step with count.
module mod_n_counter #(
    parameter int MODULUS   = 60,
    parameter int WIDTH     = 7,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             tc,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    // Repeated subtraction of ten: only used on load/constant values, never on the step path.
    function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
        logic [WIDTH+3:0] rem;
        logic [3:0]       tens;
        rem  = (WIDTH+4)'(v);
        tens = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (rem >= (WIDTH+4)'(10)) begin
                rem  = rem - (WIDTH+4)'(10);
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rem)};
    endfunction

    localparam logic [7:0] RST_BCD = to_bcd(RST_VAL);
    localparam logic [7:0] MAX_BCD = to_bcd(MAX_VAL);

    logic             at_max;
    logic             at_zero;
    logic             load_ok;
    logic [7:0]       load_bcd;
    logic [WIDTH-1:0] count_nxt;
    logic [3:0]       tens_nxt;
    logic [3:0]       ones_nxt;

    assign at_max   = (count == MAX_VAL);
    assign at_zero  = (count == '0);
    assign load_ok  = (load_val <= MAX_VAL);
    assign load_bcd = to_bcd(load_val);

    assign tc = en & ~load & ((updown & at_max) | (~updown & at_zero));

    always_comb begin
        count_nxt = count;
        tens_nxt  = bcd_tens;
        ones_nxt  = bcd_ones;
        if (updown) begin
            if (at_max) begin
                count_nxt = '0;
                tens_nxt  = 4'd0;
                ones_nxt  = 4'd0;
            end else begin
                count_nxt = count + WIDTH'(1);
                if (bcd_ones == 4'd9) begin
                    ones_nxt = 4'd0;
                    tens_nxt = bcd_tens + 4'd1;
                end else begin
                    ones_nxt = bcd_ones + 4'd1;
                end
            end
        end else begin
            if (at_zero) begin
                count_nxt = MAX_VAL;
                tens_nxt  = MAX_BCD[7:4];
                ones_nxt  = MAX_BCD[3:0];
            end else begin
                count_nxt = count - WIDTH'(1);
                if (bcd_ones == 4'd0) begin
                    ones_nxt = 4'd9;
                    tens_nxt = bcd_tens - 4'd1;
                end else begin
                    ones_nxt = bcd_ones - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= RST_VAL;
            bcd_tens <= RST_BCD[7:4];
            bcd_ones <= RST_BCD[3:0];
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count    <= load_val;
                    bcd_tens <= load_bcd[7:4];
                    bcd_ones <= load_bcd[3:0];
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                count    <= count_nxt;
                bcd_tens <= tens_nxt;
                bcd_ones <= ones_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: directed vector table, cascade and reset
// sequences, and a randomized sweep over three moduli against a behavioural model.
module tb_mod_n_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // seconds / minutes pair (MODULUS 60)
    logic       s_rst = 1'b1, s_en = 1'b0, s_up = 1'b1, s_ld = 1'b0;
    logic [6:0] s_lv  = '0;
    logic [6:0] s_cnt;
    logic [3:0] s_tens, s_ones;
    logic       s_tc, s_err;
    logic       m_ld = 1'b0;
    logic [6:0] m_lv = '0;
    logic [6:0] m_cnt;
    logic [3:0] m_tens, m_ones;
    logic       m_tc, m_err;

    // sweep instances sharing one stimulus
    logic       w_rst = 1'b1, w_en = 1'b0, w_up = 1'b1, w_ld = 1'b0;
    logic [6:0] w_lv  = '0;
    logic [3:0] a_cnt;
    logic [4:0] b_cnt;
    logic [6:0] c_cnt;
    logic [3:0] a_tens, a_ones, b_tens, b_ones, c_tens, c_ones;
    logic       a_tc, a_err, b_tc, b_err, c_tc, c_err;

    mod_n_counter #(.MODULUS(60), .WIDTH(7), .RESET_VAL(0)) u_sec (
        .clk(clk), .reset(s_rst), .en(s_en), .updown(s_up), .load(s_ld), .load_val(s_lv),
        .count(s_cnt), .bcd_tens(s_tens), .bcd_ones(s_ones), .tc(s_tc), .load_err(s_err));

    mod_n_counter #(.MODULUS(60), .WIDTH(7), .RESET_VAL(0)) u_min (
        .clk(clk), .reset(s_rst), .en(s_tc), .updown(s_up), .load(m_ld), .load_val(m_lv),
        .count(m_cnt), .bcd_tens(m_tens), .bcd_ones(m_ones), .tc(m_tc), .load_err(m_err));

    mod_n_counter #(.MODULUS(12), .WIDTH(4), .RESET_VAL(0)) u_m12 (
        .clk(clk), .reset(w_rst), .en(w_en), .updown(w_up), .load(w_ld), .load_val(w_lv[3:0]),
        .count(a_cnt), .bcd_tens(a_tens), .bcd_ones(a_ones), .tc(a_tc), .load_err(a_err));

    mod_n_counter #(.MODULUS(24), .WIDTH(5), .RESET_VAL(12)) u_m24 (
        .clk(clk), .reset(w_rst), .en(w_en), .updown(w_up), .load(w_ld), .load_val(w_lv[4:0]),
        .count(b_cnt), .bcd_tens(b_tens), .bcd_ones(b_ones), .tc(b_tc), .load_err(b_err));

    mod_n_counter #(.MODULUS(100), .WIDTH(7), .RESET_VAL(0)) u_m100 (
        .clk(clk), .reset(w_rst), .en(w_en), .updown(w_up), .load(w_ld), .load_val(w_lv),
        .count(c_cnt), .bcd_tens(c_tens), .bcd_ones(c_ones), .tc(c_tc), .load_err(c_err));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    typedef struct {
        bit rst; bit en; bit up; bit ld; int lv;
        int cnt; int tens; int ones; bit tc; bit err;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl[NVEC];

    int ma, mb, mc;

    function automatic bit mtc(input int m, input int c, input bit en, input bit up, input bit ld);
        return en && !ld && ((up && c == m - 1) || (!up && c == 0));
    endfunction

    task automatic mstep(input int m, input int rv, input int lv, input bit rst, input bit en,
                         input bit up, input bit ld, inout int c, output bit err);
        err = 1'b0;
        if (rst) c = rv;
        else if (ld) begin
            if (lv < m) c = lv;
            else err = 1'b1;
        end else if (en) begin
            if (up) c = (c == m - 1) ? 0 : c + 1;
            else    c = (c == 0) ? m - 1 : c - 1;
        end
    endtask

    task automatic sw_step(input bit rst, input bit en, input bit up, input bit ld, input logic [6:0] lv);
        bit ea, eb, ec;
        @(negedge clk);
        w_rst = rst; w_en = en; w_up = up; w_ld = ld; w_lv = lv;
        #1;
        chk("m12 tc",  a_tc, mtc(12, ma, en, up, ld));
        chk("m24 tc",  b_tc, mtc(24, mb, en, up, ld));
        chk("m100 tc", c_tc, mtc(100, mc, en, up, ld));
        @(posedge clk);
        #1;
        mstep(12,  0,  int'(lv[3:0]), rst, en, up, ld, ma, ea);
        mstep(24,  12, int'(lv[4:0]), rst, en, up, ld, mb, eb);
        mstep(100, 0,  int'(lv),      rst, en, up, ld, mc, ec);
        chk("m12 count", a_cnt, ma);  chk("m12 tens", a_tens, ma / 10);
        chk("m12 ones", a_ones, ma % 10);  chk("m12 err", a_err, ea);
        chk("m12 range", a_cnt < 4'd12, 1);
        chk("m24 count", b_cnt, mb);  chk("m24 tens", b_tens, mb / 10);
        chk("m24 ones", b_ones, mb % 10);  chk("m24 err", b_err, eb);
        chk("m24 range", b_cnt < 5'd24, 1);
        chk("m100 count", c_cnt, mc);  chk("m100 tens", c_tens, mc / 10);
        chk("m100 ones", c_ones, mc % 10);  chk("m100 err", c_err, ec);
        chk("m100 range", c_cnt < 7'd100, 1);
    endtask

    initial begin
        //            rst en up ld  lv   cnt tens ones tc err
        tbl[0]  = '{0, 0, 1, 1, 0,    0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0,   59, 5, 9, 1, 0};
        tbl[2]  = '{0, 1, 0, 0, 0,   58, 5, 8, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 42,  42, 4, 2, 0, 0};
        tbl[4]  = '{0, 0, 1, 1, 60,  42, 4, 2, 0, 1};
        tbl[5]  = '{0, 0, 1, 1, 100, 42, 4, 2, 0, 1};
        tbl[6]  = '{0, 0, 1, 0, 0,   42, 4, 2, 0, 0};
        tbl[7]  = '{0, 1, 1, 1, 7,    7, 0, 7, 0, 0};
        tbl[8]  = '{0, 1, 1, 1, 99,   7, 0, 7, 0, 1};
        tbl[9]  = '{0, 1, 1, 0, 0,    8, 0, 8, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 0,    7, 0, 7, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 0,    8, 0, 8, 0, 0};
        tbl[12] = '{0, 1, 1, 1, 59,  59, 5, 9, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 0,   58, 5, 8, 0, 0};
        tbl[14] = '{0, 1, 1, 0, 0,   59, 5, 9, 0, 0};
        tbl[15] = '{0, 0, 1, 0, 0,   59, 5, 9, 0, 0};
        tbl[16] = '{0, 1, 1, 0, 0,    0, 0, 0, 1, 0};
        tbl[17] = '{0, 1, 0, 1, 127,  0, 0, 0, 0, 1};
        tbl[18] = '{1, 1, 1, 1, 127,  0, 0, 0, 0, 0};
        tbl[19] = '{0, 1, 0, 0, 0,   59, 5, 9, 1, 0};
        tbl[20] = '{0, 1, 1, 0, 9,    0, 0, 0, 1, 0};
        tbl[21] = '{0, 1, 1, 0, 0,    1, 0, 1, 0, 0};
        tbl[22] = '{1, 1, 1, 0, 0,    0, 0, 0, 0, 0};
        tbl[23] = '{0, 0, 1, 1, 9,    9, 0, 9, 0, 0};
        tbl[24] = '{0, 1, 1, 0, 0,   10, 1, 0, 0, 0};
        tbl[25] = '{0, 1, 0, 0, 0,    9, 0, 9, 0, 0};

        // reset state
        @(posedge clk);
        #1;
        chk("reset count", s_cnt, 0);  chk("reset tens", s_tens, 0);
        chk("reset ones", s_ones, 0);  chk("reset err", s_err, 0);
        chk("reset min count", m_cnt, 0);

        // up-wrap over 61 steps
        for (int i = 1; i <= 61; i++) begin
            @(negedge clk);
            s_rst = 1'b0; s_en = 1'b1; s_up = 1'b1; s_ld = 1'b0;
            #1;
            chk("upwrap tc", s_tc, ((i - 1) % 60) == 59);
            @(posedge clk);
            #1;
            chk("upwrap count", s_cnt, i % 60);
            chk("upwrap tens", s_tens, (i % 60) / 10);
            chk("upwrap ones", s_ones, (i % 60) % 10);
        end

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            s_rst = tbl[i].rst; s_en = tbl[i].en; s_up = tbl[i].up;
            s_ld = tbl[i].ld; s_lv = 7'(tbl[i].lv);
            #1;
            chk($sformatf("vec%0d tc", i), s_tc, tbl[i].tc);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d count", i), s_cnt, tbl[i].cnt);
            chk($sformatf("vec%0d tens", i), s_tens, tbl[i].tens);
            chk($sformatf("vec%0d ones", i), s_ones, tbl[i].ones);
            chk($sformatf("vec%0d err", i), s_err, tbl[i].err);
        end

        // cascade 59:59 -> 00:00 -> 00:01
        @(negedge clk);
        s_rst = 1'b0; s_en = 1'b0; s_up = 1'b1; s_ld = 1'b1; s_lv = 7'd59; m_ld = 1'b1; m_lv = 7'd59;
        @(posedge clk);
        #1;
        chk("casc sec load", s_cnt, 59);
        chk("casc min load", m_cnt, 59);
        @(negedge clk);
        s_en = 1'b1; s_ld = 1'b0; m_ld = 1'b0;
        #1;
        chk("casc sec tc", s_tc, 1);
        chk("casc min tc", m_tc, 1);
        @(posedge clk);
        #1;
        chk("casc sec wrap", s_cnt, 0);
        chk("casc min wrap", m_cnt, 0);
        chk("casc min tens", m_tens, 0);
        chk("casc min ones", m_ones, 0);
        @(negedge clk);
        #1;
        chk("casc sec tc after", s_tc, 0);
        @(posedge clk);
        #1;
        chk("casc sec step", s_cnt, 1);
        chk("casc min hold", m_cnt, 0);
        @(negedge clk);
        s_en = 1'b0;

        // mid-operation reset on the 24-stage (RESET_VAL 12)
        ma = 0; mb = 12; mc = 0;
        sw_step(1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        chk("m24 reset count", b_cnt, 12);
        chk("m24 reset tens", b_tens, 1);
        chk("m24 reset ones", b_ones, 2);
        sw_step(1'b0, 1'b0, 1'b1, 1'b1, 7'd23);
        chk("m24 load23", b_cnt, 23);
        sw_step(1'b1, 1'b1, 1'b1, 1'b1, 7'd30);
        chk("m24 midreset count", b_cnt, 12);
        chk("m24 midreset tens", b_tens, 1);
        chk("m24 midreset ones", b_ones, 2);
        chk("m24 midreset err", b_err, 0);

        for (int n = 0; n < 10000; n++) begin
            sw_step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                    7'($urandom_range(0, 127)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
